// File: rtl/spi_slave_core.sv
// SPI target endpoint: oversampled SCLK/CS/MOSI, configurable mode and word length.
// Pin edge to internal action takes 3 GCLK cycles; rx_valid_o follows one cycle later.
// No backpressure: tx_data_i is taken at each word start; rx_data_o is overwritten per word.
module spi_slave_core (
  input  logic        GCLK,
  input  logic        NRST,
  input  logic [1:0]  spi_mode_i,
  input  logic [1:0]  word_len_i,
  input  logic [31:0] tx_data_i,
  output logic        tx_req_o,
  output logic [31:0] rx_data_o,
  output logic        rx_valid_o,
  output logic        frame_err_o,
  output logic        busy_o,
  input  logic        SCLK_i,
  input  logic        CS_i,
  input  logic        MOSI_i,
  output logic        MISO_o,
  output logic        miso_oe_o
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [2:0]  sclk_sync;
  logic [2:0]  cs_sync;
  logic [1:0]  mosi_sync;
  logic        cfg_cpol;
  logic        cfg_cpha;
  logic [1:0]  cfg_len;
  logic [31:0] tx_shift;
  logic [30:0] rx_shift;
  logic [31:0] rx_shift_nxt;
  logic [5:0]  bit_cnt;
  logic [5:0]  word_bits;
  logic [31:0] word_mask;

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic lead_edge, trail_edge, sample_edge, shift_edge;
  logic start_frame, do_sample, do_shift, word_done, frame_err;

  // Synchronizers; resetting to 0 means a CS already low at release never looks like a fall.
  always_ff @(posedge GCLK or negedge NRST) begin
    if (!NRST) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[1:0], SCLK_i};
      cs_sync   <= {cs_sync[1:0], CS_i};
      mosi_sync <= {mosi_sync[0], MOSI_i};
    end
  end

  assign sclk_rise  = sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall  = ~sclk_sync[1] & sclk_sync[2];
  assign cs_rise    = cs_sync[1] & ~cs_sync[2];
  assign cs_fall    = ~cs_sync[1] & cs_sync[2];
  assign lead_edge  = cfg_cpol ? sclk_fall : sclk_rise;
  assign trail_edge = cfg_cpol ? sclk_rise : sclk_fall;
  assign sample_edge = cfg_cpha ? trail_edge : lead_edge;
  assign shift_edge  = cfg_cpha ? lead_edge : trail_edge;

  // Word length decode from the latched frame config.
  always_comb begin
    word_bits = 6'd8;
    word_mask = 32'h0000_00FF;
    MISO_o    = tx_shift[7];
    case (cfg_len)
      2'b01: begin word_bits = 6'd16; word_mask = 32'h0000_FFFF; MISO_o = tx_shift[15]; end
      2'b10: begin word_bits = 6'd24; word_mask = 32'h00FF_FFFF; MISO_o = tx_shift[23]; end
      2'b11: begin word_bits = 6'd32; word_mask = 32'hFFFF_FFFF; MISO_o = tx_shift[31]; end
      default: ;
    endcase
  end

  assign rx_shift_nxt = {rx_shift, mosi_sync[1]};

  // State register.
  always_ff @(posedge GCLK or negedge NRST) begin
    if (!NRST) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and per-cycle strobes; a shift at bit_cnt 0 would drop the freshly loaded MSB.
  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    do_sample   = 1'b0;
    do_shift    = 1'b0;
    word_done   = 1'b0;
    frame_err   = 1'b0;
    if (state == IDLE) begin
      if (cs_fall) begin
        state_nxt   = ACTIVE;
        start_frame = 1'b1;
      end
    end else begin
      do_sample = sample_edge;
      do_shift  = shift_edge && (bit_cnt != 6'd0);
      word_done = sample_edge && ((bit_cnt + 6'd1) == word_bits);
      if (cs_rise) begin
        state_nxt = IDLE;
        frame_err = ((bit_cnt != 6'd0) || sample_edge) && !word_done;
      end
    end
  end

  // Frame config, shift registers, bit counter and output pulses.
  always_ff @(posedge GCLK or negedge NRST) begin
    if (!NRST) begin
      cfg_cpol    <= 1'b0;
      cfg_cpha    <= 1'b0;
      cfg_len     <= 2'b00;
      tx_shift    <= '0;
      rx_shift    <= '0;
      bit_cnt     <= '0;
      rx_data_o   <= '0;
      rx_valid_o  <= 1'b0;
      tx_req_o    <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      rx_valid_o  <= word_done;
      tx_req_o    <= start_frame | word_done;
      frame_err_o <= frame_err;
      if (start_frame) begin
        cfg_cpol <= spi_mode_i[1];
        cfg_cpha <= spi_mode_i[0];
        cfg_len  <= word_len_i;
        tx_shift <= tx_data_i;
        bit_cnt  <= '0;
      end else begin
        if (do_sample) begin
          rx_shift <= rx_shift_nxt[30:0];
          bit_cnt  <= word_done ? 6'd0 : bit_cnt + 6'd1;
        end
        if (word_done) begin
          rx_data_o <= rx_shift_nxt & word_mask;
          tx_shift  <= tx_data_i;
        end else if (do_shift) begin
          tx_shift <= {tx_shift[30:0], 1'b0};
        end
      end
    end
  end

  assign busy_o    = (state == ACTIVE);
  assign miso_oe_o = (state == ACTIVE);

endmodule

// File: doc/spi_slave_core.md
# spi_slave_core

SPI target (slave) endpoint that receives MOSI words from an external SPI master and returns MISO words within the same transfers. It lives entirely in the GCLK domain. SCLK, CS and MOSI are oversampled through synchronizers, not used as clocks. It supports the same mode and word-length encodings as the SPI master, so that block's bench can drive it back-to-back as a loopback target.

## Interface
- no parameters
- GCLK  in  1  system clock; all logic is clocked on its rising edge
- NRST  in  1  asynchronous active-low reset
- spi_mode_i  in  2  [1]=CPOL, [0]=CPHA; sampled at frame start
- word_len_i  in  2  00=8, 01=16, 10=24, 11=32 bits; sampled at frame start
- tx_data_i  in  32  next word to transmit, right-aligned; latched at each word start
- tx_req_o  out  1  one-cycle pulse: tx_data_i was latched; source may now present the next word
- rx_data_o  out  32  last complete received word, right-aligned, upper bits zero; held until the next word completes
- rx_valid_o  out  1  one-cycle pulse when rx_data_o updates
- frame_err_o  out  1  one-cycle pulse when CS deasserts mid-word
- busy_o  out  1  high while a frame is active (state ACTIVE)
- SCLK_i, CS_i, MOSI_i  in  1 each  SPI pins, asynchronous; CS_i is active-low
- MISO_o  out  1  serial data out, MSB first
- miso_oe_o  out  1  MISO output enable; high only in ACTIVE

## Operation
- SCLK_i, CS_i, MOSI_i each pass through 2-flop synchronizers.
- A third flop stage on SCLK and CS provides edge detection.
- FSM has two states: IDLE and ACTIVE.
- IDLE → ACTIVE on a synchronized CS falling edge. On that transition:
  - latch spi_mode_i and word_len_i into the frame config
  - load tx_shift from tx_data_i and pulse tx_req_o
  - clear bit_cnt to 0
- ACTIVE → IDLE on a synchronized CS rising edge, from any bit position.
- Edge definitions: leading edge is rising if CPOL=0, falling if CPOL=1. Trailing edge is the opposite edge.
- Sample edge: leading edge if CPHA=0, trailing edge if CPHA=1.
  - rx_shift ← {rx_shift[30:0], MOSI_sync}
  - bit_cnt increments
- Shift edge: the edge that is not the sample edge. tx_shift advances one bit.
  - CPHA=0: the MSB is presented at CS assertion, so no shift occurs before the first sample.
  - CPHA=1: the first leading edge presents the MSB and is not counted as a shift.
- MISO_o = tx_shift[N-1], where N is the frame word length. Bits above N-1 are ignored.
- Word completion, when bit_cnt reaches N on a sample edge:
  - rx_data_o ← rx_shift masked to N bits; pulse rx_valid_o
  - bit_cnt ← 0
  - reload tx_shift from tx_data_i and pulse tx_req_o, so the first bit of the next word is ready for the next shift window
- Frames may carry any number of words. Config stays fixed until CS deasserts.
- CS rising with bit_cnt ≠ 0:
  - partial word discarded; pulse frame_err_o
  - no rx_valid_o; rx_data_o unchanged
- CS rising with bit_cnt = 0 is a clean end: no error pulse.
- In IDLE, SCLK edges are ignored.
- Changes to spi_mode_i or word_len_i while ACTIVE have no effect.

## Timing
- Reset values: all outputs 0, i.e. MISO_o=0, miso_oe_o=0, busy_o=0, rx_data_o=0, all pulses low, FSM=IDLE.
- Pin-to-internal-edge latency is 3 GCLK cycles.
- rx_valid_o asserts on the cycle after the internally detected final sample edge.
- MISO_o reaches the pin ≤4 GCLK cycles after the SCLK shift edge at the pin.
- SCLK period must be ≥8 GCLK, with each half-period ≥4 GCLK.
- CS assertion to first SCLK edge must be ≥4 GCLK.
- Final SCLK edge to CS deassertion must be ≥4 GCLK. Slower timing is always legal.
- If a CS rising edge and a final sample edge are detected in the same cycle, the word completes first (rx_valid_o pulses) and there is no frame_err_o.
- tx_req_o and busy_o rise in the same cycle at frame start.
- NRST assertion mid-frame clears all state immediately.
  - After release, the core waits in IDLE for a fresh CS falling edge.
  - If CS is already low at release, no frame starts until CS goes high and then low again.

## Test plan
- Mode 0, 8-bit, master sends 0xA5, tx_data_i=0x3C → rx_data_o=0x000000A5 with one rx_valid_o pulse; master receives 0x3C; tx_req_o pulses once at frame start and once at word end.
- Mode 3, 32-bit, MOSI 0xDEADBEEF, tx 0x12345678 → rx_data_o=0xDEADBEEF; master receives 0x12345678.
- Mode 1, 16-bit, two words in one frame, MOSI 0x1234 then 0xABCD, tx_data_i changed to 0x5555 after the first tx_req_o → two rx_valid_o pulses with 0x1234 then 0xABCD; second MISO word is 0x5555.
- Mode 2, 24-bit, CS deasserted after 5 bits → frame_err_o pulses once; no rx_valid_o; rx_data_o keeps its prior value; the next full frame with 0xC0FFEE is received correctly.
- NRST pulsed mid-word with CS held low → all outputs return to 0; no rx_valid_o; the transfer after a CS high→low cycle succeeds.
- spi_mode_i and word_len_i toggled mid-frame (starting mode 0, 8-bit, 0x81) → received value is 0x81 under the original config.
